// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register (pipe_stage).
// Optional skid buffer is selected with PIPE_STAGE_SKID_EN.
package pipe_pkg;

    localparam int unsigned PIPE_DEFAULT_WIDTH = 16;

    // Encoding equals the number of held entries, so occupancy is the state itself.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/pipe_stage_if.sv
// Valid/ready payload channel between pipeline stages.
// Used unchanged by both builds of pipe_stage (PIPE_STAGE_SKID_EN on or off).
interface pipe_stage_if
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = PIPE_DEFAULT_WIDTH
);

    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    // Producer side of the channel.
    modport master (output valid, output data, input ready);
    // Consumer side of the channel.
    modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/pipe_stage.sv
// Pipeline boundary register with valid/ready handshake, flush and occupancy.
// PIPE_STAGE_SKID_EN adds a skid entry so in_ready has no path from out_ready.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH  = PIPE_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input  logic        clk,
    input  logic        rst,
    pipe_stage_if.slave  in_if,
    pipe_stage_if.master out_if,
    input  logic        flush,
    output logic [1:0]  occupancy
);

    pipe_state_e      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
`ifdef PIPE_STAGE_SKID_EN
    logic [WIDTH-1:0] skid_q, skid_d;
`endif
    logic out_valid_c;
    logic in_ready_c;
    logic xfer_in;
    logic xfer_out;

    assign xfer_in  = in_if.valid && in_ready_c;
    assign xfer_out = out_valid_c && out_if.ready;

    // State and payload registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= BUBBLE;
`ifdef PIPE_STAGE_SKID_EN
            skid_q  <= BUBBLE;
`endif
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
`ifdef PIPE_STAGE_SKID_EN
            skid_q  <= skid_d;
`endif
        end
    end

    // Next state and payload moves; flush overrides every transfer.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
`ifdef PIPE_STAGE_SKID_EN
        skid_d  = skid_q;
`endif
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = BUBBLE;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (xfer_in) begin
                        state_d = ST_ONE;
                        main_d  = in_if.data;
                    end
                end
                ST_ONE: begin
                    if (xfer_in && xfer_out) begin
                        main_d = in_if.data;
                    end else if (xfer_out) begin
                        state_d = ST_EMPTY;
                        main_d  = BUBBLE;
`ifdef PIPE_STAGE_SKID_EN
                    end else if (xfer_in) begin
                        state_d = ST_FULL;
                        skid_d  = in_if.data;
`endif
                    end
                end
                ST_FULL: begin
`ifdef PIPE_STAGE_SKID_EN
                    if (xfer_out) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
`else
                    state_d = ST_EMPTY;
                    main_d  = BUBBLE;
`endif
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = BUBBLE;
                end
            endcase
        end
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        out_valid_c = (state_q != ST_EMPTY);
`ifdef PIPE_STAGE_SKID_EN
        in_ready_c  = !rst && (state_q != ST_FULL);
`else
        // Pass-through ready: a held entry leaving frees the slot this cycle.
        in_ready_c  = !rst && (!out_valid_c || out_if.ready);
`endif
    end

    assign in_if.ready  = in_ready_c;
    assign out_if.valid = out_valid_c;
    assign out_if.data  = main_q;
    assign occupancy    = 2'(state_q);

endmodule

// File: tb/tb_pipe_stage.sv
// Self-checking bench for pipe_stage against a queue reference model.
// Expectations follow PIPE_STAGE_SKID_EN as defined for the build.
module tb_pipe_stage;

    localparam int unsigned W = 37;
    localparam logic [W-1:0] BUB = 37'h0DEADBEEF;
`ifdef PIPE_STAGE_SKID_EN
    localparam int unsigned CAP = 2;
`else
    localparam int unsigned CAP = 1;
`endif

    logic       clk;
    logic       rst;
    logic       flush;
    logic [1:0] occupancy;

    pipe_stage_if #(.WIDTH(W)) in_if ();
    pipe_stage_if #(.WIDTH(W)) out_if ();

    pipe_stage #(.WIDTH(W), .BUBBLE(BUB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_if     (in_if),
        .out_if    (out_if),
        .flush     (flush),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference: entries held by the stage, oldest first.
    logic [W-1:0] model_q[$];
    bit           bubble_known;
    int           dut_max_occ = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_ready(input bit ordy);
`ifdef PIPE_STAGE_SKID_EN
        return model_q.size() < 2;
`else
        return (model_q.size() == 0) || ordy;
`endif
    endfunction

    // Apply one cycle of inputs, check outputs before the edge, then advance the model.
    task automatic step(input bit iv, input logic [W-1:0] id, input bit ordy, input bit fl);
        bit exp_rdy;
        bit take_in;
        bit take_out;
        in_if.valid  = iv;
        in_if.data   = id;
        out_if.ready = ordy;
        flush        = fl;
        #1;
        exp_rdy = model_ready(ordy);
        check("out_valid", 64'(out_if.valid), 64'(model_q.size() != 0));
        check("occupancy", 64'(occupancy), 64'(model_q.size()));
        check("in_ready", 64'(in_if.ready), 64'(exp_rdy));
        if (model_q.size() != 0)
            check("out_data", 64'(out_if.data), 64'(model_q[0]));
        else if (bubble_known)
            check("bubble", 64'(out_if.data), 64'(BUB));
        if (int'(occupancy) > dut_max_occ) dut_max_occ = int'(occupancy);
        take_in  = iv && exp_rdy;
        take_out = (model_q.size() != 0) && ordy;
        @(posedge clk);
        if (fl) begin
            model_q.delete();
            bubble_known = 1'b1;
        end else begin
            if (take_out) void'(model_q.pop_front());
            if (take_in) begin
                model_q.push_back(id);
                bubble_known = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst          = 1'b0;
        flush        = 1'b0;
        in_if.valid  = 1'b0;
        in_if.data   = '0;
        out_if.ready = 1'b0;
        bubble_known = 1'b1;
        #1 rst = 1'b1;
        #2;
        check("rst_valid", 64'(out_if.valid), 64'd0);
        check("rst_data", 64'(out_if.data), 64'(BUB));
        check("rst_occ", 64'(occupancy), 64'd0);
        check("rst_ready", 64'(in_if.ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel_ready", 64'(in_if.ready), 64'd1);

        // Back-to-back stream at full rate.
        step(1'b1, 37'h1111, 1'b1, 1'b0);
        step(1'b1, 37'h2222, 1'b1, 1'b0);
        step(1'b1, 37'h3333, 1'b1, 1'b0);
        step(1'b0, 37'h0,    1'b1, 1'b0);
        step(1'b0, 37'h0,    1'b1, 1'b0);

        // Downstream stall with a second offer, then drain.
        step(1'b1, 37'hAAAA, 1'b0, 1'b0);
        step(1'b1, 37'hBBBB, 1'b0, 1'b0);
        step(1'b1, 37'hBBBB, 1'b0, 1'b0);
        step(1'b1, 37'hBBBB, 1'b1, 1'b0);
        step(1'b0, 37'h0,    1'b1, 1'b0);
        step(1'b0, 37'h0,    1'b1, 1'b0);

        // Flush while full with an incoming offer.
        step(1'b1, 37'hAAAA, 1'b0, 1'b0);
        step(1'b1, 37'hBBBB, 1'b0, 1'b0);
        step(1'b1, 37'hCCCC, 1'b1, 1'b1);
        step(1'b0, 37'h0,    1'b1, 1'b0);
        step(1'b0, 37'h0,    1'b1, 1'b0);

        // Asynchronous reset between edges while holding an entry.
        step(1'b1, 37'h1234, 1'b0, 1'b0);
        in_if.valid = 1'b0;
        rst = 1'b1;
        #1;
        check("arst_valid", 64'(out_if.valid), 64'd0);
        check("arst_data", 64'(out_if.data), 64'(BUB));
        check("arst_occ", 64'(occupancy), 64'd0);
        check("arst_ready", 64'(in_if.ready), 64'd0);
        model_q.delete();
        bubble_known = 1'b1;
        #1 rst = 1'b0;
        #1;
        check("arel_ready", 64'(in_if.ready), 64'd1);
        step(1'b1, 37'h5678, 1'b1, 1'b0);
        step(1'b0, 37'h0,    1'b1, 1'b0);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 10000; i++) begin
            step($urandom_range(0, 3) != 0, W'({$urandom(), $urandom()}),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
        end
        check("max_occ", 64'(dut_max_occ), 64'(CAP));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
